// File: rtl/fifo_param_rf.sv
// fifo_param_rf: parametrised synchronous FIFO over a DEPTH x DATA_W register file.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through reads (default: 1-cycle latency).
module fifo_param_rf #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned AF_LVL = 6,
   parameter int unsigned AE_LVL = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic [2:0]        state,
   output logic              wr_err,
   output logic              rd_err
);
   localparam int unsigned Depth = 2 ** ADDR_W;
   localparam int unsigned CntW  = ADDR_W + 1;

   typedef enum logic [2:0] {
      StInit  = 3'd0,
      StNoOp  = 3'd1,
      StWrite = 3'd2,
      StRead  = 3'd3,
      StRdWr  = 3'd4,
      StWrErr = 3'd5,
      StRdErr = 3'd6
   } state_e;

   logic [DATA_W-1:0] mem [Depth];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              full_q, full_d, empty_q, empty_d;
   logic              af_q, af_d, ae_q, ae_d;
   logic              wr_err_q, wr_err_d, rd_err_q, rd_err_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   state_e            state_q, state_d;
   logic              wr_acc, rd_acc;
`ifndef FIFO_FWFT_EN
   logic              rd_valid_q, rd_valid_d;
`endif

   always_comb begin
      wr_acc   = wr_en && !full_q && !clear;
      rd_acc   = rd_en && !empty_q && !clear;
      wr_ptr_d = wr_ptr_q + ADDR_W'(wr_acc);
      rd_ptr_d = rd_ptr_q + ADDR_W'(rd_acc);
      count_d  = count_q + CntW'(wr_acc) - CntW'(rd_acc);
      wr_err_d = wr_err_q | (wr_en & full_q);
      rd_err_d = rd_err_q | (rd_en & empty_q);

`ifdef FIFO_FWFT_EN
      // Register the upcoming head; an empty (or emptying) FIFO takes the incoming word.
      if (wr_acc && (rd_ptr_d == wr_ptr_q)) rd_data_d = wr_data;
      else                                  rd_data_d = mem[rd_ptr_d];
`else
      rd_data_d  = rd_acc ? mem[rd_ptr_q] : rd_data_q;
      rd_valid_d = rd_acc;
`endif

      if (clear)                    state_d = StInit;
      else if (wr_en && full_q)     state_d = StWrErr;
      else if (rd_en && empty_q)    state_d = StRdErr;
      else if (wr_en && rd_en)      state_d = StRdWr;
      else if (wr_en)               state_d = StWrite;
      else if (rd_en)               state_d = StRead;
      else                          state_d = StNoOp;

      if (clear) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         wr_err_d  = 1'b0;
         rd_err_d  = 1'b0;
         rd_data_d = '0;
`ifndef FIFO_FWFT_EN
         rd_valid_d = 1'b0;
`endif
      end

      full_d  = (count_d == CntW'(Depth));
      empty_d = (count_d == '0);
      af_d    = (count_d >= CntW'(AF_LVL));
      ae_d    = (count_d <= CntW'(AE_LVL));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
         wr_err_q   <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_data_q  <= '0;
         state_q    <= StInit;
`ifndef FIFO_FWFT_EN
         rd_valid_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         af_q       <= af_d;
         ae_q       <= ae_d;
         wr_err_q   <= wr_err_d;
         rd_err_q   <= rd_err_d;
         rd_data_q  <= rd_data_d;
         state_q    <= state_d;
`ifndef FIFO_FWFT_EN
         rd_valid_q <= rd_valid_d;
`endif
      end
   end

   // Storage is deliberately left out of reset and clear.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr_q] <= wr_data;
   end

   assign rd_data      = rd_data_q;
`ifdef FIFO_FWFT_EN
   assign rd_valid     = !empty_q;
`else
   assign rd_valid     = rd_valid_q;
`endif
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign count        = count_q;
   assign state        = state_q;
   assign wr_err       = wr_err_q;
   assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_fifo_param_rf.sv
// tb_fifo_param_rf: directed stimulus with a read-data scoreboard for fifo_param_rf.
module tb_fifo_param_rf;
   logic        clk, reset, clear, wr_en, rd_en;
   logic [31:0] wr_data, rd_data;
   logic        rd_valid, full, empty, almost_full, almost_empty, wr_err, rd_err;
   logic [3:0]  count;
   logic [2:0]  state;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [31:0] exp_q[$];

   fifo_param_rf #(
      .DATA_W(32),
      .ADDR_W(3),
      .AF_LVL(6),
      .AE_LVL(1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .state        (state),
      .wr_err       (wr_err),
      .rd_err       (rd_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of requests, then return at the following falling edge.
   task automatic step(input logic w, input logic [31:0] d, input logic r, input logic c);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      clear   = c;
      @(negedge clk);
   endtask

`ifndef FIFO_FWFT_EN
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rd_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_mis++;
               $display("FAIL rd_pop: got %0h, no word expected (t=%0t)", rd_data, $time);
            end else begin
               e = exp_q.pop_front();
               if (rd_data !== e) begin
                  n_mis++;
                  $display("FAIL rd_data: got %0h, expected %0h (t=%0t)", rd_data, e, $time);
               end
            end
         end
      end
   end
`endif

   initial begin
      reset = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_ae", almost_empty, 1);
      chk("rst_full", full, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_state", state, 0);
      chk("rst_errs", {wr_err, rd_err}, 0);

`ifdef FIFO_FWFT_EN
      step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
      chk("fwft_valid", rd_valid, 1);
      chk("fwft_data", rd_data, 32'hDEADBEEF);
      chk("fwft_count", count, 1);
      step(1'b1, 32'h12345678, 1'b0, 1'b0);
      chk("fwft_head_hold", rd_data, 32'hDEADBEEF);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fwft_next_head", rd_data, 32'h12345678);
      chk("fwft_count2", count, 1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fwft_empty", empty, 1);
      chk("fwft_valid_lo", rd_valid, 0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("fwft_rd_err", rd_err, 1);
      chk("fwft_state_rderr", state, 6);
`else
      // Reset in the middle of a write burst drops everything.
      step(1'b1, 32'h1, 1'b0, 1'b0);
      step(1'b1, 32'h2, 1'b0, 1'b0);
      step(1'b1, 32'h3, 1'b0, 1'b0);
      chk("burst_count", count, 3);
      wr_data = 32'h4;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_empty", empty, 1);
      @(negedge clk);
      reset = 1'b0; wr_en = 1'b0;
      chk("midrst_state", state, 0);
      chk("midrst_valid", rd_valid, 0);
      chk("midrst_errs", {wr_err, rd_err}, 0);

      // Fill to full, then overflow.
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 32'(i * 32'h11), 1'b0, 1'b0);
         exp_q.push_back(32'(i * 32'h11));
         chk("fill_count", count, 64'(i));
         chk("fill_af", almost_full, 64'(i >= 6));
         chk("fill_full", full, 64'(i == 8));
         chk("fill_state", state, 2);
      end
      step(1'b1, 32'h99, 1'b0, 1'b0);
      chk("ovf_wr_err", wr_err, 1);
      chk("ovf_state", state, 5);
      chk("ovf_count", count, 8);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("noop_state", state, 1);
      chk("wr_err_sticky", wr_err, 1);

      // Drain, then underflow.
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0);
         chk("drain_count", count, 64'(8 - i));
         chk("drain_ae", almost_empty, 64'((8 - i) <= 1));
      end
      chk("drain_empty", empty, 1);
      step(1'b0, 32'h0, 1'b1, 1'b0);
      chk("udf_rd_err", rd_err, 1);
      chk("udf_state", state, 6);
      chk("udf_hold", rd_data, 32'h88);
      chk("udf_valid", rd_valid, 0);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("clr_errs", {wr_err, rd_err}, 0);
      chk("clr_state", state, 0);

      // Pointer wrap at steady occupancy 4.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
         exp_q.push_back(32'hA0 + 32'(i));
      end
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 32'hB00 + 32'(i), 1'b1, 1'b0);
         exp_q.push_back(32'hB00 + 32'(i));
         chk("wrap_state", state, 4);
         chk("wrap_count", count, 4);
      end
      repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("wrap_empty", empty, 1);

      // Simultaneous requests at the empty and full boundaries.
      step(1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
      exp_q.push_back(32'hA5A5A5A5);
      chk("both_empty_count", count, 1);
      chk("both_empty_rd_err", rd_err, 1);
      chk("both_empty_state", state, 6);
      chk("both_empty_valid", rd_valid, 0);
      for (int i = 1; i <= 7; i++) begin
         step(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
         exp_q.push_back(32'hC0 + 32'(i));
      end
      chk("refill_full", full, 1);
      step(1'b1, 32'hEE, 1'b1, 1'b0);
      chk("both_full_count", count, 7);
      chk("both_full_wr_err", wr_err, 1);
      chk("both_full_state", state, 5);
      step(1'b1, 32'hFF, 1'b1, 1'b1);
      chk("clear_count", count, 0);
      chk("clear_empty", empty, 1);
      chk("clear_errs", {wr_err, rd_err}, 0);
      chk("clear_state", state, 0);
      chk("clear_valid", rd_valid, 0);
      exp_q.delete();
      step(1'b0, 32'h0, 1'b0, 1'b0);
      chk("post_clear_count", count, 0);
      chk("sb_leftover", 64'(exp_q.size()), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
